// File: rtl/spi_reg_bridge.sv
// SPI frame decoder in the system clock domain: synchronizes csb/sclk, counts bits,
// then applies each 16-bit command to the control register file or stages a read reply.
module spi_reg_bridge #(
    parameter int         NUM_REGS    = 16,
    parameter logic [6:0] STATUS_ADDR = 7'h7F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb,
    input  logic                  sclk,
    input  logic [15:0]           spi_datao,
    output logic [15:0]           spi_datai,
    input  logic [7:0]            status_i,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_stb,
    output logic [6:0]            wr_addr,
    output logic                  frame_err,
    output logic                  overrun
);
    localparam logic [7:0] LP_NR = 8'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, ACTIVE, DECODE, LOAD} state_t;

    state_t      r_state, w_next;
    logic        r_csb_m, r_csb_s, r_csb_d;
    logic        r_sclk_m, r_sclk_s, r_sclk_d;
    logic [1:0]  r_warm;
    logic [7:0]  r_cnt;
    logic [15:0] r_reply;
    logic        r_reply_ok;
    logic [7:0]  r_regs [NUM_REGS];

    logic        w_csb_fall, w_csb_rise, w_sclk_rise;
    logic        w_clr_cnt, w_inc_cnt, w_do_dec, w_load, w_ovr;
    logic        w_wr, w_in_range;
    logic [6:0]  w_addr;
    logic [7:0]  w_wdata, w_rd, w_reply;

    // A fall is only trusted once the edge-detect flop holds a real sample,
    // so the reset value of the synchronizer cannot fake a frame start.
    assign w_csb_fall  = r_csb_d & ~r_csb_s & (r_warm == 2'd3);
    assign w_csb_rise  = ~r_csb_d & r_csb_s;
    assign w_sclk_rise = ~r_sclk_d & r_sclk_s;

    assign w_wr       = spi_datao[15];
    assign w_addr     = spi_datao[14:8];
    assign w_wdata    = spi_datao[7:0];
    assign w_in_range = ({1'b0, w_addr} < LP_NR);

    always_comb begin
        w_rd = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (w_addr == k[6:0]) w_rd = r_regs[k];
    end

    always_comb begin
        w_reply = 8'h00;
        if (w_in_range)                 w_reply = w_wr ? w_wdata : w_rd;
        else if (w_addr == STATUS_ADDR) w_reply = status_i;
    end

    always_comb begin
        w_next    = r_state;
        w_clr_cnt = 1'b0;
        w_inc_cnt = 1'b0;
        w_do_dec  = 1'b0;
        w_load    = 1'b0;
        w_ovr     = 1'b0;
        case (r_state)
            IDLE: if (w_csb_fall) begin
                w_clr_cnt = 1'b1;
                w_next    = ACTIVE;
            end
            ACTIVE: begin
                w_inc_cnt = w_sclk_rise;
                if (w_csb_rise) w_next = DECODE;
            end
            DECODE: begin
                w_do_dec = 1'b1;
                w_next   = LOAD;
            end
            default: begin
                // A raw fall already inside the synchronizer is too late to load safely.
                if (!r_csb_s || !r_csb_m) begin
                    w_clr_cnt = 1'b1;
                    w_ovr     = r_reply_ok;
                    w_next    = ACTIVE;
                end else begin
                    w_load = r_reply_ok;
                    w_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_csb_m    <= 1'b1;
            r_csb_s    <= 1'b1;
            r_csb_d    <= 1'b1;
            r_sclk_m   <= 1'b0;
            r_sclk_s   <= 1'b0;
            r_sclk_d   <= 1'b0;
            r_warm     <= 2'd0;
            r_cnt      <= 8'd0;
            r_reply    <= 16'h0000;
            r_reply_ok <= 1'b0;
            spi_datai  <= 16'h0000;
            wr_stb     <= 1'b0;
            wr_addr    <= 7'd0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= 8'h00;
        end else begin
            r_state   <= w_next;
            r_csb_m   <= csb;
            r_csb_s   <= r_csb_m;
            r_csb_d   <= r_csb_s;
            r_sclk_m  <= sclk;
            r_sclk_s  <= r_sclk_m;
            r_sclk_d  <= r_sclk_s;
            if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= w_ovr;

            if (w_clr_cnt)                       r_cnt <= 8'd0;
            else if (w_inc_cnt && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;

            if (w_do_dec) begin
                r_reply_ok <= 1'b0;
                if (r_cnt != 8'd16 || (w_wr && !w_in_range)) begin
                    frame_err <= 1'b1;
                end else begin
                    if (w_wr) begin
                        for (int k = 0; k < NUM_REGS; k++)
                            if (w_addr == k[6:0]) r_regs[k] <= w_wdata;
                        wr_stb  <= 1'b1;
                        wr_addr <= w_addr;
                    end
                    r_reply    <= {1'b0, w_addr, w_reply};
                    r_reply_ok <= 1'b1;
                end
            end

            if (w_load) spi_datai <= r_reply;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign regs_o[k*8 +: 8] = r_regs[k];
    end
endmodule
